// File: rtl/kiwi_directorate_pkg.sv
// Shared types and constants for the kiwi directorate controller.
package kiwi_directorate_pkg;

    // Controller phases; only StIdle accepts a new run.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StLoad = 2'b01,
        StRun  = 2'b10,
        StDone = 2'b11
    } state_e;

    // Host-visible completion codes.
    typedef enum logic [1:0] {
        StatusOk      = 2'b00,
        StatusAbend   = 2'b01,
        StatusTimeout = 2'b10,
        StatusAborted = 2'b11
    } status_e;

    localparam logic [7:0] SYND_NONE = 8'h00;
    localparam logic [7:0] SYND_EXIT = 8'h80;

    // A clean exit or a plain finish with no syndrome counts as success.
    function automatic status_e kernel_status(input logic [7:0] synd);
        return ((synd == SYND_EXIT) || (synd == SYND_NONE)) ? StatusOk : StatusAbend;
    endfunction

endpackage

// File: rtl/kiwi_directorate_ctrl_if.sv
// Host and kernel signal bundle of the kiwi directorate controller.
// master: the environment (host + kernel); slave: the controller.
interface kiwi_directorate_ctrl_if #(
    parameter int unsigned PC_WIDTH = 2
);
    import kiwi_directorate_pkg::*;

    logic                host_start;
    logic [63:0]         host_arg;
    logic                host_abort;
    logic                host_busy;
    logic                host_done;
    logic [1:0]          host_status;
    logic [63:0]         host_result;
    logic [7:0]          host_syndrome;
    logic [7:0]          host_waypoint;
    logic [PC_WIDTH-1:0] host_pc;
    logic [31:0]         run_cycles;
    logic                kern_run;
    logic [63:0]         kern_widein;
    logic [63:0]         kern_wideout;
    logic [7:0]          kern_abend;
    logic [7:0]          kern_waypoint;
    logic [PC_WIDTH-1:0] kern_pc;
    logic                kern_finish;

    modport master (
        output host_start, host_arg, host_abort,
        output kern_wideout, kern_abend, kern_waypoint, kern_pc, kern_finish,
        input  host_busy, host_done, host_status, host_result, host_syndrome,
        input  host_waypoint, host_pc, run_cycles, kern_run, kern_widein
    );

    modport slave (
        input  host_start, host_arg, host_abort,
        input  kern_wideout, kern_abend, kern_waypoint, kern_pc, kern_finish,
        output host_busy, host_done, host_status, host_result, host_syndrome,
        output host_waypoint, host_pc, run_cycles, kern_run, kern_widein
    );

endinterface

// File: rtl/kiwi_run_counter.sv
// Saturating 32-bit cycle counter with synchronous clear (clear wins over enable).
module kiwi_run_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    output logic [31:0] count
);

    logic [31:0] count_q;

    // Count enabled cycles, sticking at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != 32'hFFFF_FFFF)) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/kiwi_directorate_ctrl.sv
// Kiwi directorate controller: sequences one kernel run per host start and
// captures the kernel's result, syndrome, waypoint and PC when it stops.
// Optional run watchdog: define KIWI_DIRECTORATE_WATCHDOG_EN.
module kiwi_directorate_ctrl
    import kiwi_directorate_pkg::*;
#(
    parameter int unsigned WATCHDOG_CYCLES = 1024,
    parameter int unsigned PC_WIDTH        = 2
) (
    input logic                    clk,
    input logic                    reset,
    kiwi_directorate_ctrl_if.slave bus
);

    state_e              state_q, state_d;
    status_e             status_q, cap_status;
    logic                capture;
    logic                start_accept;
    logic                kern_stop;
    logic [63:0]         widein_q;
    logic [63:0]         result_q;
    logic [7:0]          syndrome_q;
    logic [7:0]          waypoint_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [31:0]         run_cycles;

    assign kern_stop = bus.kern_finish || (bus.kern_abend != SYND_NONE);

`ifdef KIWI_DIRECTORATE_WATCHDOG_EN
    logic wd_hit;
    assign wd_hit = (run_cycles == (WATCHDOG_CYCLES - 32'd1));
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and stop decision; abort outranks kernel stop outranks watchdog.
    always_comb begin
        state_d      = state_q;
        capture      = 1'b0;
        cap_status   = StatusOk;
        start_accept = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.host_start) begin
                    start_accept = 1'b1;
                    state_d      = StLoad;
                end
            end
            StLoad: begin
                if (bus.host_abort) begin
                    capture    = 1'b1;
                    cap_status = StatusAborted;
                    state_d    = StDone;
                end else begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (bus.host_abort) begin
                    capture    = 1'b1;
                    cap_status = StatusAborted;
                    state_d    = StDone;
                end else if (kern_stop) begin
                    capture    = 1'b1;
                    cap_status = kernel_status(bus.kern_abend);
                    state_d    = StDone;
                end
`ifdef KIWI_DIRECTORATE_WATCHDOG_EN
                else if (wd_hit) begin
                    capture    = 1'b1;
                    cap_status = StatusTimeout;
                    state_d    = StDone;
                end
`endif
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Run argument and stop-time capture registers; they hold until reloaded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            widein_q   <= '0;
            result_q   <= '0;
            syndrome_q <= '0;
            waypoint_q <= '0;
            pc_q       <= '0;
            status_q   <= StatusOk;
        end else begin
            if (start_accept) begin
                widein_q <= bus.host_arg;
            end
            if (capture) begin
                result_q   <= bus.kern_wideout;
                syndrome_q <= bus.kern_abend;
                waypoint_q <= bus.kern_waypoint;
                pc_q       <= bus.kern_pc;
                status_q   <= cap_status;
            end
        end
    end

    kiwi_run_counter u_run_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (start_accept),
        .enable (state_q == StRun),
        .count  (run_cycles)
    );

    // Strobes decode straight from the state so reset removes them at once.
    assign bus.host_busy     = (state_q != StIdle);
    assign bus.host_done     = (state_q == StDone);
    assign bus.kern_run      = (state_q == StRun);
    assign bus.host_status   = status_q;
    assign bus.host_result   = result_q;
    assign bus.host_syndrome = syndrome_q;
    assign bus.host_waypoint = waypoint_q;
    assign bus.host_pc       = pc_q;
    assign bus.run_cycles    = run_cycles;
    assign bus.kern_widein   = widein_q;

endmodule

// File: tb/tb_kiwi_directorate_ctrl.sv
// Bench for kiwi_directorate_ctrl: per-cycle comparison against a run-level
// model, plus directed scenarios with literal expectations.
module tb_kiwi_directorate_ctrl;

    localparam int unsigned WD = 16;
`ifdef KIWI_DIRECTORATE_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_seen = 0;

    kiwi_directorate_ctrl_if #(.PC_WIDTH(2)) bus ();

    kiwi_directorate_ctrl #(
        .WATCHDOG_CYCLES (WD),
        .PC_WIDTH        (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: a run is "busy" from acceptance until its done cycle ends; the
    // kernel is enabled from the second busy cycle until the stop edge.
    logic        m_busy     = 1'b0;
    logic        m_done     = 1'b0;
    int          m_age      = 0;
    logic [63:0] m_widein   = '0;
    logic [63:0] m_result   = '0;
    logic [7:0]  m_synd     = '0;
    logic [7:0]  m_wp       = '0;
    logic [1:0]  m_pc       = '0;
    logic [1:0]  m_status   = '0;
    logic [31:0] m_cycles   = '0;
    wire         m_run      = m_busy && !m_done && (m_age > 0);
    wire         m_kstop    = m_run && (bus.kern_finish || bus.kern_abend != 8'h00);
    wire         m_wd       = m_run && WD_EN && (m_cycles == WD - 1);
    wire         m_abort    = m_busy && !m_done && bus.host_abort;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 0; m_done <= 0; m_age <= 0; m_widein <= 0; m_result <= 0;
            m_synd <= 0; m_wp <= 0; m_pc <= 0; m_status <= 0; m_cycles <= 0;
        end else if (m_done) begin
            m_done <= 0;
            m_busy <= 0;
        end else if (!m_busy) begin
            if (bus.host_start) begin
                m_busy <= 1; m_age <= 0; m_widein <= bus.host_arg; m_cycles <= 0;
            end
        end else begin
            m_age <= m_age + 1;
            if (m_run && m_cycles != 32'hFFFF_FFFF) m_cycles <= m_cycles + 1;
            if (m_abort || m_kstop || m_wd) begin
                m_done   <= 1;
                m_result <= bus.kern_wideout;
                m_synd   <= bus.kern_abend;
                m_wp     <= bus.kern_waypoint;
                m_pc     <= bus.kern_pc;
                if (m_abort) m_status <= 2'd3;
                else if (m_kstop)
                    m_status <= (bus.kern_abend == 8'h80 || bus.kern_abend == 8'h00) ? 2'd0 : 2'd1;
                else m_status <= 2'd2;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("kern_run", 64'(bus.kern_run), 64'(m_run));
        chk("host_busy", 64'(bus.host_busy), 64'(m_busy));
        chk("host_done", 64'(bus.host_done), 64'(m_done));
        chk("host_status", 64'(bus.host_status), 64'(m_status));
        chk("host_result", bus.host_result, m_result);
        chk("host_syndrome", 64'(bus.host_syndrome), 64'(m_synd));
        chk("host_waypoint", 64'(bus.host_waypoint), 64'(m_wp));
        chk("host_pc", 64'(bus.host_pc), 64'(m_pc));
        chk("run_cycles", 64'(bus.run_cycles), 64'(m_cycles));
        chk("kern_widein", bus.kern_widein, m_widein);
        if (bus.host_done) done_seen++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_run(input logic [63:0] arg);
        bus.host_arg   = arg;
        bus.host_start = 1'b1;
        tick(1);
        bus.host_start = 1'b0;
    endtask

    task automatic wait_run();
        int k = 0;
        while (!bus.kern_run && k < 10) begin
            tick(1);
            k++;
        end
        chk("wait_run_reached", 64'(bus.kern_run), 64'd1);
    endtask

    task automatic clear_kern();
        bus.kern_finish = 0; bus.kern_abend = 0; bus.kern_waypoint = 0;
        bus.kern_pc = 0; bus.kern_wideout = 0; bus.host_abort = 0;
    endtask

    initial begin
        int d0;
        bus.host_start = 0; bus.host_arg = 0;
        clear_kern();
        tick(3);
        chk("rst_busy", 64'(bus.host_busy), 64'd0);
        chk("rst_run", 64'(bus.kern_run), 64'd0);
        chk("rst_result", bus.host_result, 64'd0);
        reset = 1'b1;
        tick(1);

        // Clean finish on the fifth RUN cycle.
        start_run(64'h0123_4567_89AB_CDEF);
        chk("load_run_low", 64'(bus.kern_run), 64'd0);
        chk("load_busy", 64'(bus.host_busy), 64'd1);
        tick(5);
        bus.kern_finish = 1; bus.kern_abend = 8'h80; bus.kern_wideout = 64'hDEAD;
        bus.kern_waypoint = 8'h11; bus.kern_pc = 2'd2;
        tick(1);
        clear_kern();
        chk("t1_done", 64'(bus.host_done), 64'd1);
        chk("t1_status", 64'(bus.host_status), 64'd0);
        chk("t1_result", bus.host_result, 64'hDEAD);
        chk("t1_cycles", 64'(bus.run_cycles), 64'd5);
        chk("t1_widein", bus.kern_widein, 64'h0123_4567_89AB_CDEF);
        tick(1);
        chk("t1_idle_busy", 64'(bus.host_busy), 64'd0);

        // Abort while loading.
        start_run(64'h1111);
        bus.host_abort = 1;
        tick(1);
        clear_kern();
        chk("load_abort_status", 64'(bus.host_status), 64'd3);
        chk("load_abort_cycles", 64'(bus.run_cycles), 64'd0);
        tick(1);

        // Abend with waypoint.
        start_run(64'h2222);
        wait_run();
        tick(2);
        bus.kern_abend = 8'h21; bus.kern_waypoint = 8'h07; bus.kern_pc = 2'd1;
        bus.kern_wideout = 64'h55;
        tick(1);
        clear_kern();
        chk("t2_status", 64'(bus.host_status), 64'd1);
        chk("t2_synd", 64'(bus.host_syndrome), 64'h21);
        chk("t2_wp", 64'(bus.host_waypoint), 64'h07);
        tick(1);

        // Abort together with a kernel finish.
        start_run(64'h3333);
        wait_run();
        tick(1);
        bus.host_abort = 1; bus.kern_finish = 1; bus.kern_abend = 8'h80;
        bus.kern_wideout = 64'hBEEF;
        tick(1);
        clear_kern();
        chk("t4_status", 64'(bus.host_status), 64'd3);
        chk("t4_result", bus.host_result, 64'hBEEF);
        tick(1);

        // Starts during RUN and DONE are dropped.
        d0 = done_seen;
        start_run(64'hAAAA);
        wait_run();
        tick(1);
        bus.host_start = 1; bus.host_arg = 64'hBBBB;
        tick(1);
        bus.host_start = 0;
        tick(1);
        bus.kern_finish = 1;
        tick(1);
        clear_kern();
        chk("t5_done", 64'(bus.host_done), 64'd1);
        bus.host_start = 1; bus.host_arg = 64'hCCCC;
        tick(1);
        bus.host_start = 0;
        chk("t5_idle", 64'(bus.host_busy), 64'd0);
        chk("t5_widein", bus.kern_widein, 64'hAAAA);
        tick(5);
        chk("t5_single_done", 64'(done_seen - d0), 64'd1);

        // Watchdog.
        start_run(64'h4444);
        if (WD_EN) begin
            int k = 0;
            while (!bus.host_done && k < 40) begin
                tick(1);
                k++;
            end
            chk("wd_done", 64'(bus.host_done), 64'd1);
            chk("wd_status", 64'(bus.host_status), 64'd2);
            chk("wd_cycles", 64'(bus.run_cycles), 64'd16);
        end else begin
            tick(40);
            chk("nowd_running", 64'(bus.kern_run), 64'd1);
            chk("nowd_cycles", 64'(bus.run_cycles), 64'd39);
            bus.host_abort = 1;
            tick(1);
            clear_kern();
            chk("nowd_abort", 64'(bus.host_status), 64'd3);
        end
        tick(2);

        // Asynchronous reset mid-run.
        start_run(64'h5555);
        wait_run();
        tick(2);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_run", 64'(bus.kern_run), 64'd0);
        chk("arst_busy", 64'(bus.host_busy), 64'd0);
        chk("arst_cycles", 64'(bus.run_cycles), 64'd0);
        chk("arst_widein", bus.kern_widein, 64'd0);
        d0 = done_seen;
        tick(2);
        reset = 1'b1;
        tick(3);
        chk("arst_no_done", 64'(done_seen - d0), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
